// File: rtl/cop0_irq_sequencer.sv
// CPU-side interrupt entry / ERET sequencer for the COP0 coprocessor.
// Takes precise interrupts in EX, runs ERET as an EPC read then Status write, and passes MFC0/MTC0 through otherwise.
module cop0_irq_sequencer #(
    parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180,
    parameter logic [4:0]  EPC_ADDR       = 5'h4,
    parameter logic [4:0]  STATUS_ADDR    = 5'hC
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InterruptRequest,
    output logic        InterruptHandled,
    output logic [31:0] InterruptedPC,
    output logic [4:0]  Cop0Address,
    output logic        Cop0WriteEnable,
    output logic [31:0] Cop0WriteData,
    input  logic [31:0] Cop0ReadData,
    input  logic        ExValid,
    input  logic [31:0] ExPC,
    input  logic        ExInDelaySlot,
    input  logic        Stall,
    input  logic        InstMfc0,
    input  logic        InstMtc0,
    input  logic        InstEret,
    input  logic [4:0]  InstRd,
    input  logic [31:0] InstWriteData,
    output logic [31:0] ReadData,
    output logic        Flush,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic        Busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TAKE     = 3'd1;
    localparam logic [2:0] HOLDOFF  = 3'd2;
    localparam logic [2:0] ERET_EPC = 3'd3;
    localparam logic [2:0] ERET_IE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        eligible;

    assign eligible = ExValid & ~Stall;

    always_comb begin
        state_d          = state_q;
        epc_d            = epc_q;
        InterruptHandled = 1'b0;
        InterruptedPC    = epc_q;
        Cop0Address      = InstRd;
        Cop0WriteEnable  = 1'b0;
        Cop0WriteData    = InstWriteData;
        ReadData         = Cop0ReadData;
        Flush            = 1'b0;
        Redirect         = 1'b0;
        RedirectPC       = HANDLER_VECTOR;
        Busy             = 1'b0;

        case (state_q)
            IDLE: begin
                if (eligible && InterruptRequest) begin
                    // A delay-slot instruction restarts from its branch.
                    Flush   = 1'b1;
                    epc_d   = ExInDelaySlot ? ExPC - 32'd4 : ExPC;
                    state_d = TAKE;
                end else if (eligible && InstEret) begin
                    Flush   = 1'b1;
                    state_d = ERET_EPC;
                end else begin
                    Cop0WriteEnable = InstMtc0 & eligible;
                end
            end
            TAKE: begin
                InterruptHandled = 1'b1;
                Redirect         = 1'b1;
                Busy             = 1'b1;
                state_d          = HOLDOFF;
            end
            HOLDOFF: begin
                Busy    = 1'b1;
                state_d = IDLE;
            end
            ERET_EPC: begin
                Cop0Address = EPC_ADDR;
                epc_d       = Cop0ReadData;
                Busy        = 1'b1;
                state_d     = ERET_IE;
            end
            ERET_IE: begin
                Cop0Address     = STATUS_ADDR;
                Cop0WriteEnable = 1'b1;
                Cop0WriteData   = Cop0ReadData | 32'h1;
                Redirect        = 1'b1;
                RedirectPC      = epc_q;
                Busy            = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so the state may still be mid-sequence this cycle.
        if (Reset) begin
            InterruptHandled = 1'b0;
            Flush            = 1'b0;
            Redirect         = 1'b0;
            Busy             = 1'b0;
            Cop0WriteEnable  = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            epc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

endmodule

// File: tb/tb_cop0_irq_sequencer.sv
// Randomized bench for cop0_irq_sequencer with a transaction-level reference model and a small COP0 register file.
module tb_cop0_irq_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        InterruptRequest = 1'b0;
    logic        InterruptHandled;
    logic [31:0] InterruptedPC;
    logic [4:0]  Cop0Address;
    logic        Cop0WriteEnable;
    logic [31:0] Cop0WriteData;
    logic [31:0] Cop0ReadData;
    logic        ExValid = 1'b0;
    logic [31:0] ExPC = 32'd0;
    logic        ExInDelaySlot = 1'b0;
    logic        Stall = 1'b0;
    logic        InstMfc0 = 1'b0;
    logic        InstMtc0 = 1'b0;
    logic        InstEret = 1'b0;
    logic [4:0]  InstRd = 5'd0;
    logic [31:0] InstWriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        flush, handled, redirect, busy, we, chk_addr, chk_rdata;
        logic [31:0] ipc, rpc, wdata, rdata;
        logic [4:0]  addr;
    } exp_rec_t;

    exp_rec_t    pending[$];
    logic [31:0] cop0_mem[32];
    logic [31:0] model_mem[32];

    cop0_irq_sequencer dut (
        .Clock(Clock), .Reset(Reset),
        .InterruptRequest(InterruptRequest), .InterruptHandled(InterruptHandled),
        .InterruptedPC(InterruptedPC), .Cop0Address(Cop0Address),
        .Cop0WriteEnable(Cop0WriteEnable), .Cop0WriteData(Cop0WriteData),
        .Cop0ReadData(Cop0ReadData), .ExValid(ExValid), .ExPC(ExPC),
        .ExInDelaySlot(ExInDelaySlot), .Stall(Stall), .InstMfc0(InstMfc0),
        .InstMtc0(InstMtc0), .InstEret(InstEret), .InstRd(InstRd),
        .InstWriteData(InstWriteData), .ReadData(ReadData), .Flush(Flush),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Behavioural COP0 register file seen by the DUT.
    assign Cop0ReadData = cop0_mem[Cop0Address];
    always @(posedge Clock) begin
        if (Cop0WriteEnable) cop0_mem[Cop0Address] <= Cop0WriteData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic exp_rec_t blankRec();
        exp_rec_t r;
        r.flush = 0; r.handled = 0; r.redirect = 0; r.busy = 0; r.we = 0;
        r.chk_addr = 0; r.chk_rdata = 0;
        r.ipc = 0; r.rpc = 0; r.wdata = 0; r.rdata = 0; r.addr = 0;
        return r;
    endfunction

    task automatic compareRec(input exp_rec_t e);
        checkOutput("flush",    {31'd0, Flush},            {31'd0, e.flush});
        checkOutput("handled",  {31'd0, InterruptHandled}, {31'd0, e.handled});
        checkOutput("redirect", {31'd0, Redirect},         {31'd0, e.redirect});
        checkOutput("busy",     {31'd0, Busy},             {31'd0, e.busy});
        checkOutput("cop0_we",  {31'd0, Cop0WriteEnable},  {31'd0, e.we});
        if (e.handled)   checkOutput("interrupted_pc", InterruptedPC, e.ipc);
        if (e.redirect)  checkOutput("redirect_pc", RedirectPC, e.rpc);
        if (e.chk_addr)  checkOutput("cop0_addr", {27'd0, Cop0Address}, {27'd0, e.addr});
        if (e.we)        checkOutput("cop0_wdata", Cop0WriteData, e.wdata);
        if (e.chk_rdata) checkOutput("read_data", ReadData, e.rdata);
    endtask

    // Reference model: a free cycle decides an event and schedules the fixed
    // per-cycle outcome of the whole sequence into a queue.
    task automatic evaluateCycle();
        exp_rec_t e, r;
        logic     elig;
        e = blankRec();
        if (Reset) begin
            pending.delete();
            compareRec(e);
        end else if (pending.size() > 0) begin
            e = pending.pop_front();
            compareRec(e);
            if (e.we) model_mem[e.addr] = e.wdata;
        end else begin
            elig = ExValid && !Stall;
            if (elig && InterruptRequest) begin
                e.flush = 1;
                compareRec(e);
                r = blankRec();
                r.handled = 1; r.redirect = 1; r.busy = 1;
                r.ipc = ExInDelaySlot ? ExPC - 32'd4 : ExPC;
                r.rpc = 32'h0000_0180;
                pending.push_back(r);
                r = blankRec();
                r.busy = 1;
                pending.push_back(r);
            end else if (elig && InstEret) begin
                e.flush = 1;
                compareRec(e);
                r = blankRec();
                r.busy = 1; r.chk_addr = 1; r.addr = 5'h4;
                pending.push_back(r);
                r = blankRec();
                r.busy = 1; r.chk_addr = 1; r.addr = 5'hC; r.we = 1;
                r.wdata = model_mem[12] | 32'h1;
                r.redirect = 1; r.rpc = model_mem[4];
                pending.push_back(r);
            end else begin
                e.chk_addr = 1; e.addr = InstRd;
                e.chk_rdata = 1; e.rdata = model_mem[InstRd];
                e.we = elig && InstMtc0;
                e.wdata = InstWriteData;
                compareRec(e);
                if (e.we) model_mem[InstRd] = InstWriteData;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic irq, input logic valid, input logic stall,
                                 input logic ds, input logic [1:0] op, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic [31:0] wd);
        @(posedge Clock);
        #1;
        Reset = rst; InterruptRequest = irq; ExValid = valid; Stall = stall;
        ExInDelaySlot = ds; ExPC = pc; InstRd = rd; InstWriteData = wd;
        InstMfc0 = (op == 2'd1); InstMtc0 = (op == 2'd2); InstEret = (op == 2'd3);
        #3;
        evaluateCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 2'd0, 5'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            cop0_mem[i] = v;
            model_mem[i] = v;
        end
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 5'd0, 32'd0, 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 2'd2, 5'd3, 32'h40, 32'h5);
        idleCycles(1);
        // Plain interrupt, delay-slot interrupt, interrupt over an MTC0.
        applyStimulus(0, 1, 1, 0, 0, 2'd0, 5'd0, 32'h100, 32'd0);
        idleCycles(3);
        applyStimulus(0, 1, 1, 0, 1, 2'd0, 5'd0, 32'h204, 32'd0);
        idleCycles(3);
        applyStimulus(0, 1, 1, 0, 0, 2'd2, 5'hB, 32'h348, 32'hDEAD_BEEF);
        idleCycles(3);
        // ERET with known EPC and Status.
        applyStimulus(0, 0, 1, 0, 0, 2'd2, 5'h4, 32'h10, 32'h300);
        applyStimulus(0, 0, 1, 0, 0, 2'd2, 5'hC, 32'h14, 32'h0000_FC00);
        applyStimulus(0, 0, 1, 0, 0, 2'd1, 5'hC, 32'h18, 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 2'd3, 5'd0, 32'h1C, 32'd0);
        idleCycles(3);
        // Interrupt held off by stall.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, 0, 2'd0, 5'd0, 32'h500, 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 2'd0, 5'd0, 32'h500, 32'd0);
        idleCycles(3);
        // Reset landing in the EPC-read cycle of an ERET.
        applyStimulus(0, 0, 1, 0, 0, 2'd3, 5'd0, 32'h600, 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 5'd0, 32'd0, 32'd0);
        idleCycles(2);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                          1'($urandom), op, 5'($urandom), {$urandom} & 32'hFFFF_FFFC | 32'($urandom_range(0, 1)),
                          $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
